// File: rtl/count_sched.sv
`default_nettype none
// ============================================================================
// Module      : count_sched
// Description : Round-robin scheduler that shares one loadable WIDTH-bit
//               up-counter between NUM_REQ requesters. A granted requester
//               gets its start value loaded into the counter. When the counter
//               reaches all-ones, the owner gets a one-cycle done pulse.
// Ports       : clk        - system clock, rising-edge active
//               rst        - asynchronous, active-low reset
//               req_i      - level request, one bit per requester
//               req_val_i  - start value per requester, slice [k*WIDTH +: WIDTH]
//               count_i    - current counter value (counter count_o)
//               load_o     - counter load strobe (counter load_i)
//               load_val_o - counter load value (counter load_val_i)
//               gnt_o      - one-hot owner of the current run
//               done_o     - one-cycle completion pulse to the owner
//               busy_o     - high whenever the scheduler is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module count_sched #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*WIDTH-1:0]   req_val_i,
    input  logic [WIDTH-1:0]           count_i,
    output logic                       load_o,
    output logic [WIDTH-1:0]           load_val_o,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       busy_o
);

    localparam int                 IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WIDTH-1:0]   C_TERMINAL = '1;
    localparam logic [IW:0]        C_NUM_REQ  = (IW+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] C_ONE      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [IW-1:0]      r_ptr;      // requester with highest priority next
    logic [IW-1:0]      r_idx;      // owner of the current run

    logic               w_found;
    logic [IW-1:0]      w_win;
    logic [IW:0]        w_cand;
    logic [WIDTH-1:0]   w_win_val;
    logic [IW:0]        w_idx_inc;
    logic [IW-1:0]      w_next_ptr;

    // Round-robin search: scan NUM_REQ positions starting at r_ptr, wrapping
    // modulo NUM_REQ. One extra bit in w_cand holds the pre-wrap sum.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = {1'b0, r_ptr} + (IW+1)'(i);
            if (w_cand >= C_NUM_REQ) begin
                w_cand = w_cand - C_NUM_REQ;
            end
            if (!w_found && req_i[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_cand[IW-1:0];
            end
        end
    end

    assign w_win_val  = req_val_i[w_win*WIDTH +: WIDTH];

    // Pointer moves just past the requester that was served.
    assign w_idx_inc  = {1'b0, r_idx} + (IW+1)'(1);
    assign w_next_ptr = (w_idx_inc == C_NUM_REQ) ? '0 : w_idx_inc[IW-1:0];

    // load_val_o doubles as the latched start value; it is written only on
    // the IDLE->LOAD transition, so it holds through LOAD, RUN and DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            load_o     <= 1'b0;
            load_val_o <= '0;
            gnt_o      <= '0;
            done_o     <= '0;
            busy_o     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state    <= S_LOAD;
                        r_idx      <= w_win;
                        load_o     <= 1'b1;
                        load_val_o <= w_win_val;
                        gnt_o      <= C_ONE << w_win;
                        busy_o     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_state <= S_RUN;
                    load_o  <= 1'b0;
                end
                S_RUN: begin
                    if (count_i == C_TERMINAL) begin
                        r_state <= S_DONE;
                        done_o  <= C_ONE << r_idx;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ptr   <= w_next_ptr;
                    gnt_o   <= '0;
                    done_o  <= '0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    load_o  <= 1'b0;
                    gnt_o   <= '0;
                    done_o  <= '0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_sched
// Description : Directed self-checking bench for count_sched. A behavioural
//               loadable counter closes the loop. Expected runs (owner,
//               start value) are queued when requests are driven and popped
//               as each run is observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sched;

    localparam int NUM_REQ = 2;
    localparam int WIDTH   = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*WIDTH-1:0] req_val_i;
    logic [WIDTH-1:0]         count_i = '0;
    logic                     load_o;
    logic [WIDTH-1:0]         load_val_o;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     busy_o;

    typedef struct {
        int              idx;
        logic [WIDTH-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    count_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .req_val_i  (req_val_i),
        .count_i    (count_i),
        .load_o     (load_o),
        .load_val_o (load_val_o),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    // Shared counter: loads on load_o, otherwise increments and wraps.
    always @(posedge clk) begin
        if (load_o) count_i <= load_val_o;
        else        count_i <= count_i + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe one complete run and compare it with the head of the scoreboard.
    // max_wait bounds the cycles until load_o; clr_mask is the requester(s)
    // dropped on seeing done; mid_change perturbs inputs on the first RUN cycle.
    task automatic do_run(input string tag, input int max_wait,
                          input logic [NUM_REQ-1:0] clr_mask, input bit mid_change);
        exp_t               e;
        int                 n;
        bit                 seen;
        bit                 hold_bad;
        logic [NUM_REQ-1:0] oh;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e  = sb.pop_front();
        oh = NUM_REQ'(1) << e.idx;

        seen = 0;
        for (int w = 0; w < max_wait && !seen; w++) begin
            @(negedge clk);
            seen = load_o;
        end
        chk({tag, "_load_seen"}, 32'(seen), 1);
        if (!seen) return;
        chk({tag, "_load_val"}, 32'(load_val_o), 32'(e.val));
        chk({tag, "_gnt_load"}, 32'(gnt_o), 32'(oh));
        chk({tag, "_busy_load"}, 32'(busy_o), 1);

        n = 0; seen = 0; hold_bad = 0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            n++;
            if (done_o !== '0) begin
                seen = 1;
            end else begin
                if (load_o !== 1'b0 || gnt_o !== oh || load_val_o !== e.val || busy_o !== 1'b1)
                    hold_bad = 1;
                if (mid_change && n == 1) begin
                    req_i     = '0;
                    req_val_i = ~req_val_i;
                end
            end
        end
        chk({tag, "_run_hold_bad"}, 32'(hold_bad), 0);
        chk({tag, "_done_seen"}, 32'(seen), 1);
        if (!seen) return;
        chk({tag, "_done"}, 32'(done_o), 32'(oh));
        chk({tag, "_gnt_done"}, 32'(gnt_o), 32'(oh));
        chk({tag, "_run_len"}, 32'(n - 1), 32'(16 - int'(e.val)));
        req_i = req_i & ~clr_mask;

        @(negedge clk);
        chk({tag, "_done_cleared"}, 32'(done_o), 0);
        chk({tag, "_gnt_idle"}, 32'(gnt_o), 0);
        chk({tag, "_busy_idle"}, 32'(busy_o), 0);
    endtask

    initial begin
        exp_t e;
        bit   seen;
        rst       = 1'b0;
        req_i     = '0;
        req_val_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_load", 32'(load_o), 0);
        chk("rst_load_val", 32'(load_val_o), 0);
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        rst = 1'b1;

        // Single run from 0: 16 RUN cycles
        req_val_i = {4'h0, 4'h0};
        req_i     = 2'b01;
        e.idx = 0; e.val = 4'h0; sb.push_back(e);
        do_run("single", 3, 2'b01, 0);

        // Both requesting from reset: 0 first, then 1 after one IDLE cycle
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req_val_i = {4'hC, 4'h3};
        req_i     = 2'b11;
        e.idx = 0; e.val = 4'h3; sb.push_back(e);
        e.idx = 1; e.val = 4'hC; sb.push_back(e);
        do_run("both0", 2, 2'b01, 0);
        do_run("both1", 1, 2'b10, 0);

        // Fairness with both held: 0,1,0,1
        req_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            e.idx = k % 2; e.val = (k % 2 == 0) ? 4'h3 : 4'hC; sb.push_back(e);
        end
        do_run("fair0", 2, 2'b00, 0);
        do_run("fair1", 1, 2'b00, 0);
        do_run("fair2", 1, 2'b00, 0);
        do_run("fair3", 1, 2'b11, 0);

        // Start value all-ones: single RUN cycle
        req_val_i = {4'h0, 4'hF};
        req_i     = 2'b01;
        e.idx = 0; e.val = 4'hF; sb.push_back(e);
        do_run("edge", 3, 2'b01, 0);

        // Mid-run input changes are ignored
        req_val_i = {4'h5, 4'h0};
        req_i     = 2'b10;
        e.idx = 1; e.val = 4'h5; sb.push_back(e);
        do_run("mid", 3, 2'b00, 1);

        // Async reset during requester 1's run, then requester 0 wins
        req_val_i = {4'h8, 4'hE};
        req_i     = 2'b11;
        e.idx = 0; e.val = 4'hE; sb.push_back(e);
        do_run("pre_rst", 3, 2'b00, 0);
        seen = 0;
        for (int w = 0; w < 2 && !seen; w++) begin
            @(negedge clk);
            seen = load_o;
        end
        chk("pre_rst_r1_load", 32'(seen), 1);
        chk("pre_rst_r1_gnt", 32'(gnt_o), 32'(2'b10));
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_load", 32'(load_o), 0);
        chk("arst_load_val", 32'(load_val_o), 0);
        chk("arst_gnt", 32'(gnt_o), 0);
        chk("arst_done", 32'(done_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        @(negedge clk);
        rst = 1'b1;
        e.idx = 0; e.val = 4'hE; sb.push_back(e);
        do_run("post_rst", 3, 2'b11, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
